dmem_port_arbiter: RTL and testbench

//  Shares the single data-memory port between the pipeline core's MEM stage and an auxiliary

---
 rtl/dmem_port_arbiter.sv | 103 ++++++++++
 tb/tb_dmem_port_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter.sv
// Data-memory port arbiter: core MEM stage has priority, aux requester
// gets a forced slot after MAX_WAIT cycles of starvation.
module dmem_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int WORD_WIDTH = 32,
  parameter int MAX_WAIT   = 4
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  core_req,
  input  logic                  core_wr_en,
  input  logic [ADDR_WIDTH-1:0] core_addr,
  input  logic [WORD_WIDTH-1:0] core_wdata,
  output logic [WORD_WIDTH-1:0] core_rdata,
  output logic                  core_stall,
  input  logic                  aux_req,
  input  logic                  aux_wr_en,
  input  logic [ADDR_WIDTH-1:0] aux_addr,
  input  logic [WORD_WIDTH-1:0] aux_wdata,
  output logic                  aux_gnt,
  output logic                  aux_rvalid,
  output logic [WORD_WIDTH-1:0] aux_rdata,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic [WORD_WIDTH-1:0] dmem_data_in,
  output logic                  dmem_wr_en,
  input  logic [WORD_WIDTH-1:0] dmem_data_out
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] LAST = CW'(MAX_WAIT - 1);

  typedef enum logic {
    ARB   = 1'b0,
    FORCE = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_wait_cnt;
  logic [CW-1:0] w_wait_nxt;

  logic w_force;
  logic w_aux_sel;
  logic w_gnt;
  logic w_rd_done;

  assign w_force   = (r_state == FORCE);
  assign w_aux_sel = w_force | (~core_req & aux_req);
  assign w_gnt     = w_aux_sel;
  assign w_rd_done = w_gnt & ~aux_wr_en;

  // Forcing is decided from registered state only, so aux_gnt has
  // no combinational dependence on core_req during a forced slot.
  always_comb begin
    w_state_nxt = ARB;
    w_wait_nxt  = '0;
    if (!w_force && aux_req && !w_gnt) begin
      if (r_wait_cnt == LAST) begin
        w_state_nxt = FORCE;
      end else begin
        w_wait_nxt = r_wait_cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state    <= ARB;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      aux_rvalid <= 1'b0;
      aux_rdata  <= '0;
    end else begin
      aux_rvalid <= w_rd_done;
      if (w_rd_done) begin
        aux_rdata <= dmem_data_out;
      end
    end
  end

  always_comb begin
    dmem_addr    = core_addr;
    dmem_data_in = core_wdata;
    dmem_wr_en   = nrst & core_req & core_wr_en;
    if (w_aux_sel) begin
      dmem_addr    = aux_addr;
      dmem_data_in = aux_wdata;
      dmem_wr_en   = nrst & aux_wr_en;
    end
  end

  assign aux_gnt    = nrst & w_gnt;
  assign core_stall = nrst & w_force & core_req;
  assign core_rdata = dmem_data_out;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a small behavioural dmem.
module tb_dmem_port_arbiter;

  logic        clk;
  logic        nrst;
  logic        core_req;
  logic        core_wr_en;
  logic [31:0] core_addr;
  logic [31:0] core_wdata;
  logic [31:0] core_rdata;
  logic        core_stall;
  logic        aux_req;
  logic        aux_wr_en;
  logic [31:0] aux_addr;
  logic [31:0] aux_wdata;
  logic        aux_gnt;
  logic        aux_rvalid;
  logic [31:0] aux_rdata;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_data_in;
  logic        dmem_wr_en;
  logic [31:0] dmem_data_out;

  logic [31:0] mem [64];
  int checks;
  int errors;

  dmem_port_arbiter #(
    .ADDR_WIDTH(32),
    .WORD_WIDTH(32),
    .MAX_WAIT(4)
  ) dut (
    .clk(clk),
    .nrst(nrst),
    .core_req(core_req),
    .core_wr_en(core_wr_en),
    .core_addr(core_addr),
    .core_wdata(core_wdata),
    .core_rdata(core_rdata),
    .core_stall(core_stall),
    .aux_req(aux_req),
    .aux_wr_en(aux_wr_en),
    .aux_addr(aux_addr),
    .aux_wdata(aux_wdata),
    .aux_gnt(aux_gnt),
    .aux_rvalid(aux_rvalid),
    .aux_rdata(aux_rdata),
    .dmem_addr(dmem_addr),
    .dmem_data_in(dmem_data_in),
    .dmem_wr_en(dmem_wr_en),
    .dmem_data_out(dmem_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign dmem_data_out = mem[dmem_addr[7:2]];

  always @(posedge clk) begin
    if (dmem_wr_en) mem[dmem_addr[7:2]] <= dmem_data_in;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic core_set(input logic req, input logic we,
                          input logic [31:0] a, input logic [31:0] d);
    core_req   = req;
    core_wr_en = we;
    core_addr  = a;
    core_wdata = d;
  endtask

  task automatic aux_set(input logic req, input logic we,
                         input logic [31:0] a, input logic [31:0] d);
    aux_req   = req;
    aux_wr_en = we;
    aux_addr  = a;
    aux_wdata = d;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    nrst = 1'b0;
    core_set(0, 0, 0, 0);
    aux_set(0, 0, 0, 0);
    repeat (2) step();
    #1;
    chk("rst_rvalid", {31'b0, aux_rvalid}, 0);
    chk("rst_rdata", aux_rdata, 0);
    chk("rst_stall", {31'b0, core_stall}, 0);
    nrst = 1'b1;

    // 1: core store then load
    step();
    core_set(1, 1, 32'h10, 32'hDEADBEEF);
    #1;
    chk("t1_st_we", {31'b0, dmem_wr_en}, 1);
    chk("t1_st_stall", {31'b0, core_stall}, 0);
    step();
    core_set(1, 0, 32'h10, 0);
    #1;
    chk("t1_ld_data", core_rdata, 32'hDEADBEEF);
    chk("t1_ld_stall", {31'b0, core_stall}, 0);

    // 2: aux read with core idle
    step();
    core_set(0, 0, 0, 0);
    aux_set(1, 0, 32'h10, 0);
    #1;
    chk("t2_gnt", {31'b0, aux_gnt}, 1);
    step();
    aux_set(0, 0, 0, 0);
    #1;
    chk("t2_rvalid", {31'b0, aux_rvalid}, 1);
    chk("t2_rdata", aux_rdata, 32'hDEADBEEF);
    step();
    #1;
    chk("t2_rvalid_off", {31'b0, aux_rvalid}, 0);

    // 3: starvation forces aux slot in cycle 4
    for (int c = 0; c < 4; c++) begin
      step();
      core_set(1, 1, 32'h40 + 32'(c * 4), 32'hC0 + 32'(c));
      aux_set(1, 1, 32'h20, 32'h1234);
      #1;
      chk($sformatf("t3_gnt_c%0d", c), {31'b0, aux_gnt}, 0);
      chk($sformatf("t3_stall_c%0d", c), {31'b0, core_stall}, 0);
    end
    step();
    core_set(1, 1, 32'h50, 32'hC4);
    #1;
    chk("t3_gnt_c4", {31'b0, aux_gnt}, 1);
    chk("t3_stall_c4", {31'b0, core_stall}, 1);
    chk("t3_addr_c4", dmem_addr, 32'h20);
    step();
    aux_set(0, 0, 0, 0);
    #1;
    chk("t3_gnt_c5", {31'b0, aux_gnt}, 0);
    chk("t3_stall_c5", {31'b0, core_stall}, 0);
    chk("t3_aux_landed", mem[8], 32'h1234);
    chk("t3_no_stalled_wr", mem[20], 0);
    chk("t3_c3_landed", mem[19], 32'hC3);
    step();
    core_set(0, 0, 0, 0);
    #1;
    chk("t3_core_landed", mem[20], 32'hC4);

    // 4: same-address contention, aux forced after core write
    step();
    core_set(1, 1, 32'h30, 32'hA);
    aux_set(1, 1, 32'h30, 32'hB);
    for (int c = 1; c < 5; c++) begin
      step();
      core_set(1, 0, 32'h0, 0);
      #1;
      if (c == 1) chk("t4_core_first", mem[12], 32'hA);
      if (c == 4) chk("t4_gnt_c4", {31'b0, aux_gnt}, 1);
    end
    step();
    aux_set(0, 0, 0, 0);
    core_set(0, 0, 0, 0);
    #1;
    chk("t4_final", mem[12], 32'hB);

    // 5: aux drops at wait_cnt=2, counter restarts
    for (int c = 0; c < 6; c++) begin
      step();
      core_set(1, 0, 32'h0, 0);
      aux_set(c != 2, 0, 32'h10, 0);
      #1;
      chk($sformatf("t5_gnt_c%0d", c), {31'b0, aux_gnt}, 0);
      chk($sformatf("t5_stall_c%0d", c), {31'b0, core_stall}, 0);
    end

    // 6: reset during a forced aux write
    step();
    aux_set(0, 0, 0, 0);
    for (int c = 0; c < 4; c++) begin
      step();
      core_set(1, 0, 32'h0, 0);
      aux_set(1, 1, 32'h60, 32'h77);
    end
    step();
    #1;
    chk("t6_forced", {31'b0, aux_gnt}, 1);
    chk("t6_we_pre", {31'b0, dmem_wr_en}, 1);
    nrst = 1'b0;
    #1;
    chk("t6_rst_we", {31'b0, dmem_wr_en}, 0);
    chk("t6_rst_gnt", {31'b0, aux_gnt}, 0);
    chk("t6_rst_stall", {31'b0, core_stall}, 0);
    step();
    #1;
    chk("t6_no_write", mem[24], 0);
    chk("t6_rst_rvalid", {31'b0, aux_rvalid}, 0);
    core_set(0, 0, 0, 0);
    aux_set(0, 0, 0, 0);
    nrst = 1'b1;
    step();
    core_set(1, 0, 32'h0, 0);
    aux_set(1, 0, 32'h10, 0);
    #1;
    chk("t6_arb_gnt", {31'b0, aux_gnt}, 0);
    chk("t6_arb_stall", {31'b0, core_stall}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
